// File: rtl/fetch_unit.sv
// fetch_unit: PC, fetch address and IR with field slicing and PC redirects.
// Optional retired-instruction counter enabled by FETCH_RETIRE_CNT_EN.
module fetch_unit #(
  parameter int               ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instrEn,
  input  logic              increment,
  input  logic              displace,
  input  logic              replace,
  input  logic              unconditional,
  input  logic              jal,
  input  logic [ADDR_W-1:0] rtarget,
  input  logic [15:0]       mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        opcode,
  output logic [3:0]        rdest,
  output logic [3:0]        bitpattern,
  output logic [3:0]        opcodeex,
  output logic [3:0]        rsrc,
  output logic [7:0]        imm8,
  output logic [ADDR_W-1:0] link_addr,
  output logic [31:0]       retired
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              redir_pending_q, redir_pending_d;
  logic [ADDR_W-1:0] redir_pc_q, redir_pc_d;
  logic [ADDR_W-1:0] disp_tgt, tgt;
  logic              redirect;

  assign mem_addr   = pc_q;
  assign opcode     = ir_q[15:12];
  assign rdest      = ir_q[11:8];
  assign bitpattern = ir_q[11:8];
  assign opcodeex   = ir_q[7:4];
  assign rsrc       = ir_q[3:0];
  assign imm8       = ir_q[7:0];
  assign link_addr  = pc_q + ADDR_W'(1);

  // Redirect target selection, jal highest priority down to displace.
  always_comb begin
    disp_tgt = pc_q + ADDR_W'(signed'(ir_q[7:0]));
    redirect = jal | replace | unconditional | displace;
    tgt      = disp_tgt;
    if (jal)
      tgt = rtarget;
    else if (replace)
      tgt = rtarget;
    else if (unconditional)
      tgt = (ir_q[15:12] == 4'b1100) ? disp_tgt : rtarget;
    else if (displace)
      tgt = disp_tgt;
  end

  // Next-state for PC, IR and the pending-redirect holding register.
  always_comb begin
    pc_d            = pc_q;
    ir_d            = instrEn ? mem_data : ir_q;
    redir_pending_d = redir_pending_q;
    redir_pc_d      = redir_pc_q;
    if (increment) begin
      redir_pending_d = 1'b0;
      if (redirect)
        pc_d = tgt;
      else if (redir_pending_q)
        pc_d = redir_pc_q;
      else
        pc_d = pc_q + ADDR_W'(1);
    end else if (redirect) begin
      redir_pending_d = 1'b1;
      redir_pc_d      = tgt;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= RESET_PC;
      ir_q            <= '0;
      redir_pending_q <= 1'b0;
      redir_pc_q      <= '0;
    end else begin
      pc_q            <= pc_d;
      ir_q            <= ir_d;
      redir_pending_q <= redir_pending_d;
      redir_pc_q      <= redir_pc_d;
    end
  end

`ifdef FETCH_RETIRE_CNT_EN
  logic [31:0] retired_q, retired_d;

  // Count every increment edge as one retired instruction.
  always_comb begin
    retired_d = increment ? retired_q + 32'd1 : retired_q;
  end

  // Retired counter register.
  always_ff @(posedge clk) begin
    if (rst) retired_q <= '0;
    else     retired_q <= retired_d;
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table plus scoreboard sequences for fetch_unit.
// Expectations are queued at drive time and compared after the clock edge.
module tb_fetch_unit;

  localparam logic [6:0] RST = 7'h40;
  localparam logic [6:0] IEN = 7'h20;
  localparam logic [6:0] INC = 7'h10;
  localparam logic [6:0] DSP = 7'h08;
  localparam logic [6:0] RPL = 7'h04;
  localparam logic [6:0] UNC = 7'h02;
  localparam logic [6:0] JAL = 7'h01;

  localparam int S_PC = 0, S_OP = 1, S_RD = 2, S_BP = 3;
  localparam int S_OX = 4, S_RS = 5, S_IM = 6, S_LK = 7, S_RT = 8;

  logic        clk = 1'b0;
  logic        rst, instrEn, increment, displace;
  logic        replace, unconditional, jal;
  logic [15:0] rtarget, mem_data;
  logic [15:0] mem_addr, link_addr;
  logic [3:0]  opcode, rdest, bitpattern, opcodeex, rsrc;
  logic [7:0]  imm8;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;
  int nincr  = 0;

  typedef struct {
    string       nm;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [15:0] md;
    logic [3:0]  op, rd, ox, rs;
    logic [7:0]  im;
  } fv_t;
  fv_t tbl[4];

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .instrEn(instrEn),
    .increment(increment), .displace(displace),
    .replace(replace), .unconditional(unconditional),
    .jal(jal), .rtarget(rtarget), .mem_data(mem_data),
    .mem_addr(mem_addr), .opcode(opcode), .rdest(rdest),
    .bitpattern(bitpattern), .opcodeex(opcodeex),
    .rsrc(rsrc), .imm8(imm8), .link_addr(link_addr),
    .retired(retired)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      S_PC:    return 32'(mem_addr);
      S_OP:    return 32'(opcode);
      S_RD:    return 32'(rdest);
      S_BP:    return 32'(bitpattern);
      S_OX:    return 32'(opcodeex);
      S_RS:    return 32'(rsrc);
      S_IM:    return 32'(imm8);
      S_LK:    return 32'(link_addr);
      default: return retired;
    endcase
  endfunction

  function automatic logic [31:0] exp_ret();
`ifdef FETCH_RETIRE_CNT_EN
    return 32'(nincr);
`else
    return 32'd0;
`endif
  endfunction

  task automatic expect_v(string nm, int sel, logic [31:0] v);
    exp_t e;
    e.nm = nm; e.sel = sel; e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] a;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      a = actual(e.sel);
      checks++;
      if (a !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0h want %0h", e.nm, a, e.exp);
      end
    end
  endtask

  task automatic chk_now(string nm, int sel, logic [31:0] v);
    expect_v(nm, sel, v);
    drain();
  endtask

  task automatic cyc(logic [6:0] s, logic [15:0] rt);
    rst           = s[6];
    instrEn       = s[5];
    increment     = s[4];
    displace      = s[3];
    replace       = s[2];
    unconditional = s[1];
    jal           = s[0];
    rtarget       = rt;
    if (s[6]) nincr = 0;
    else if (s[4]) nincr++;
    @(posedge clk);
    #1;
    rst = 0; instrEn = 0; increment = 0; displace = 0;
    replace = 0; unconditional = 0; jal = 0;
    drain();
  endtask

  task automatic step_pc(logic [6:0] s, logic [15:0] rt,
                         string nm, logic [15:0] p);
    expect_v(nm, S_PC, 32'(p));
    cyc(s, rt);
  endtask

  initial begin
    tbl[0] = '{16'h5A37, 4'h5, 4'hA, 4'h3, 4'h7, 8'h37};
    tbl[1] = '{16'hC0FE, 4'hC, 4'h0, 4'hF, 4'hE, 8'hFE};
    tbl[2] = '{16'hFFFF, 4'hF, 4'hF, 4'hF, 4'hF, 8'hFF};
    tbl[3] = '{16'h1234, 4'h1, 4'h2, 4'h3, 4'h4, 8'h34};

    mem_data = '0;
    cyc(RST, 16'h0);

    expect_v("rst_pc", S_PC, 32'h0);
    expect_v("rst_op", S_OP, 32'h0);
    expect_v("rst_rd", S_RD, 32'h0);
    expect_v("rst_ox", S_OX, 32'h0);
    expect_v("rst_rs", S_RS, 32'h0);
    expect_v("rst_im", S_IM, 32'h0);
    expect_v("rst_lk", S_LK, 32'h1);
    expect_v("rst_rt", S_RT, 32'h0);
    drain();

    for (int i = 1; i <= 3; i++)
      step_pc(INC, 16'h0, "inc", 16'(i));
    chk_now("ret3", S_RT, exp_ret());

    for (int i = 0; i < 4; i++) begin
      mem_data = tbl[i].md;
      expect_v("f_op", S_OP, 32'(tbl[i].op));
      expect_v("f_rd", S_RD, 32'(tbl[i].rd));
      expect_v("f_bp", S_BP, 32'(tbl[i].rd));
      expect_v("f_ox", S_OX, 32'(tbl[i].ox));
      expect_v("f_rs", S_RS, 32'(tbl[i].rs));
      expect_v("f_im", S_IM, 32'(tbl[i].im));
      expect_v("f_pc", S_PC, 32'h3);
      cyc(IEN, 16'h0);
    end

    for (int i = 0; i < 13; i++) cyc(INC, 16'h0);
    chk_now("pc10", S_PC, 32'h10);

    mem_data = 16'hC0FE;
    cyc(IEN, 16'h0);
    step_pc(DSP, 16'h0, "dsp_hold", 16'h0010);
    step_pc(INC, 16'h0, "dsp_neg", 16'h000E);
    cyc(INC, 16'h0);
    cyc(INC, 16'h0);
    mem_data = 16'h0005;
    cyc(IEN, 16'h0);
    step_pc(DSP | INC, 16'h0, "dsp_same", 16'h0015);

    for (int i = 0; i < 11; i++) cyc(INC, 16'h0);
    chk_now("pc20", S_PC, 32'h20);
    chk_now("jal_lk", S_LK, 32'h21);
    step_pc(JAL, 16'h0100, "jal_hold", 16'h0020);
    step_pc(INC, 16'h0000, "jal_tgt", 16'h0100);

    step_pc(RPL | DSP | INC, 16'h0040, "prio_rd", 16'h0040);
    mem_data = 16'hC0FE;
    cyc(IEN, 16'h0);
    step_pc(UNC | INC, 16'h0200, "unc_c", 16'h003E);
    step_pc(RPL | UNC | INC, 16'h0300, "prio_ru", 16'h0300);
    mem_data = 16'h5A37;
    cyc(IEN, 16'h0);
    step_pc(UNC | INC, 16'h0077, "unc_r", 16'h0077);

    step_pc(DSP, 16'h0, "ovr_a", 16'h0077);
    step_pc(RPL, 16'h0500, "ovr_b", 16'h0077);
    mem_data = 16'h1234;
    expect_v("pend_ir", S_OP, 32'h1);
    cyc(IEN, 16'h0);
    step_pc(INC, 16'h0, "ovr_tgt", 16'h0500);
    step_pc(INC, 16'h0, "pend_clr", 16'h0501);

    step_pc(RPL | INC, 16'hFFFF, "to_ffff", 16'hFFFF);
    chk_now("wrap_lk", S_LK, 32'h0);
    step_pc(INC, 16'h0, "wrap_pc", 16'h0000);
    chk_now("ret_pre", S_RT, exp_ret());

    cyc(DSP, 16'h0);
    expect_v("rst2_pc", S_PC, 32'h0);
    cyc(RST, 16'h0);
    chk_now("rst2_rt", S_RT, exp_ret());
    step_pc(INC, 16'h0, "rst2_inc", 16'h0001);
    chk_now("ret_end", S_RT, exp_ret());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
